// File: rtl/vpg_mode_apply.sv
// vpg_mode_apply: applies a requested video mode by blanking, reconfiguring the pixel PLL and reloading timing
module vpg_mode_apply #(
  parameter int LOCK_STABLE = 16,
  parameter int TIMEOUT_W   = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vpg_mode_change,
  input  logic [3:0] vpg_mode,
  input  logic       frame_end,
  input  logic       pll_reconfig_ack,
  input  logic       pll_locked,
  output logic       pll_reconfig_req,
  output logic [3:0] pll_mode,
  output logic       timing_load,
  output logic [3:0] active_mode,
  output logic       video_enable,
  output logic       busy,
  output logic       error
);
  localparam logic [3:0] MODE_FHD = 4'd4;
  localparam int CNT_W = $clog2(LOCK_STABLE + 1);
  typedef enum logic [2:0] {IDLE, DRAIN, REQ, WAIT_LOCK, LOAD} state_t;
  state_t state_q, state_d;
  logic chg_q, lk1_q, lk2_q;
  logic req_q, req_d, video_q, video_d, err_q, err_d, pend_q, pend_d, reentry;
  logic [3:0] target_q, target_d, mode_q, mode_d, active_q, active_d;
  logic [TIMEOUT_W-1:0] to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic chg_ok, tmo, lock_ok;
  assign chg_ok   = vpg_mode_change & ~chg_q & (vpg_mode <= MODE_FHD);
  assign target_d = chg_ok ? vpg_mode : target_q;
  assign tmo      = &to_q;
  assign lock_ok  = cnt_q == CNT_W'(LOCK_STABLE);
  // next-state logic; every entry into REQ latches the newest target onto pll_mode
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    mode_d  = mode_q;
    err_d   = err_q;
    reentry = 1'b0;
    pend_d  = pend_q | (chg_ok & (state_q == REQ || state_q == WAIT_LOCK || state_q == LOAD));
    case (state_q)
      IDLE: if (chg_ok) state_d = DRAIN;
      DRAIN: if (frame_end | tmo) begin
        state_d = REQ;
        req_d   = 1'b1;
        mode_d  = target_d;
      end
      REQ: if (req_q & pll_reconfig_ack) begin
        state_d = WAIT_LOCK;
        req_d   = 1'b0;
      end else if (!req_q) begin
        req_d  = 1'b1;
        mode_d = target_d;
      end else if (tmo) begin
        req_d   = 1'b0;
        err_d   = 1'b1;
        reentry = 1'b1;
      end
      WAIT_LOCK: if (lock_ok) begin
        state_d = LOAD;
        err_d   = 1'b0;
      end else if (tmo) begin
        state_d = REQ;
        req_d   = 1'b1;
        mode_d  = target_d;
        err_d   = 1'b1;
      end
      LOAD: begin
        pend_d  = 1'b0;
        state_d = (pend_q | chg_ok) ? REQ : IDLE;
        req_d   = pend_q | chg_ok;
        mode_d  = (pend_q | chg_ok) ? target_d : mode_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign active_d = (state_d == LOAD && state_q != LOAD) ? mode_q : active_q;
  assign video_d  = (state_d == IDLE) & (video_q | (state_q == LOAD));
  assign to_d     = (state_d != state_q || reentry) ? '0 : tmo ? to_q : to_q + 1'b1;
  assign cnt_d    = (state_q == WAIT_LOCK && state_d == WAIT_LOCK && lk2_q) ? cnt_q + 1'b1 : '0;
  // two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk1_q <= 1'b0;
      lk2_q <= 1'b0;
    end else begin
      lk1_q <= pll_locked;
      lk2_q <= lk1_q;
    end
  end
  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      chg_q    <= 1'b1;
      req_q    <= 1'b0;
      video_q  <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      target_q <= MODE_FHD;
      mode_q   <= MODE_FHD;
      active_q <= MODE_FHD;
      to_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      chg_q    <= vpg_mode_change;
      req_q    <= req_d;
      video_q  <= video_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
    end
  end
  assign pll_reconfig_req = req_q;
  assign pll_mode         = mode_q;
  assign timing_load      = state_q == LOAD;
  assign active_mode      = active_q;
  assign video_enable     = video_q;
  assign busy             = state_q != IDLE;
  assign error            = err_q;
endmodule

// File: tb/tb_vpg_mode_apply.sv
// tb_vpg_mode_apply: randomized scoreboard bench for the mode-change responder
module tb_vpg_mode_apply;
  logic clk = 0, reset_n = 0, vpg_mode_change = 1, frame_end = 0, pll_reconfig_ack = 0, pll_locked = 1;
  logic [3:0] vpg_mode = 0;
  logic pll_reconfig_req, timing_load, video_enable, busy, error;
  logic [3:0] pll_mode, active_mode;
  int n_chk = 0, n_fail = 0, n_load = 0, n, l0;
  logic [3:0] exp_req[$], exp_load[$];
  logic [3:0] m, x, e;
  logic req_prev = 0;
  bit early;

  always #5 clk = ~clk;

  vpg_mode_apply #(.LOCK_STABLE(16), .TIMEOUT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .vpg_mode_change(vpg_mode_change), .vpg_mode(vpg_mode),
    .frame_end(frame_end), .pll_reconfig_ack(pll_reconfig_ack), .pll_locked(pll_locked),
    .pll_reconfig_req(pll_reconfig_req), .pll_mode(pll_mode), .timing_load(timing_load),
    .active_mode(active_mode), .video_enable(video_enable), .busy(busy), .error(error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit sig(input int s);
    return s == 0 ? pll_reconfig_req : s == 1 ? timing_load : !busy;
  endfunction

  task automatic wait_sig(input int s, input int max, input string nm);
    int k = 0;
    while (!sig(s) && k < max) begin
      cyc(1);
      k++;
    end
    chk(nm, sig(s), 1);
  endtask

  task automatic pulse_ack(input int dly);
    cyc(dly);
    pll_reconfig_ack = 1;
    cyc(1);
    pll_reconfig_ack = 0;
    chk("req_drop_on_ack", pll_reconfig_req, 0);
  endtask

  // one full sequence; the expected mode is simply the last in-range code requested
  task automatic run_seq(input logic [3:0] md, input int hold, input bit use_x, input logic [3:0] xc,
                         input int fe, input int ack);
    logic [3:0] want = md;
    vpg_mode = md;
    vpg_mode_change = 1;
    cyc(1);
    chk("busy_after_chg", busy, 1);
    chk("video_off_after_chg", video_enable, 0);
    cyc(hold - 1);
    vpg_mode_change = 0;
    if (use_x) begin
      cyc(1);
      vpg_mode = xc;
      vpg_mode_change = 1;
      cyc(1);
      vpg_mode_change = 0;
      if (xc <= 4) want = xc;
    end
    exp_req.push_back(want);
    exp_load.push_back(want);
    cyc(fe);
    frame_end = 1;
    cyc(1);
    frame_end = 0;
    chk("req_after_frame_end", pll_reconfig_req, 1);
    pulse_ack(ack);
    wait_sig(1, 40, "timing_load_seen");
    cyc(1);
    chk("video_on_after_load", video_enable, 1);
    chk("busy_clear_after_load", busy, 0);
    chk("active_mode_final", active_mode, want);
  endtask

  // scoreboard monitor: pops expectations whenever the DUT requests or loads
  always @(negedge clk) begin
    if (timing_load) begin
      n_load++;
      if (exp_load.size() == 0) chk("unexpected_load", 1, 0);
      else begin
        chk("active_mode_at_load", active_mode, exp_load.pop_front());
        chk("error_at_load", error, 0);
        chk("video_at_load", video_enable, 0);
      end
    end
    if (pll_reconfig_req && !req_prev) begin
      if (exp_req.size() == 0) chk("unexpected_req", 1, 0);
      else chk("pll_mode_at_req", pll_mode, exp_req.pop_front());
    end
    req_prev <= pll_reconfig_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(2);
    chk("rst_req", pll_reconfig_req, 0);
    chk("rst_load", timing_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_video", video_enable, 0);
    chk("rst_pll_mode", pll_mode, 4);
    chk("rst_active_mode", active_mode, 4);
    reset_n = 1;
    cyc(3);
    chk("no_false_edge", busy, 0);
    vpg_mode_change = 0;
    cyc(2);
    foreach (exp_req[i]) e = exp_req[i];
    for (int c = 5; c < 16; c += 5) begin
      vpg_mode = 4'(c);
      vpg_mode_change = 1;
      cyc(1);
      vpg_mode_change = 0;
      cyc(2);
      chk("invalid_code_ignored", busy, 0);
    end
    run_seq(4'd0, 1, 0, 0, 5, 3);
    chk("vga_pll_mode", pll_mode, 0);
    chk("vga_error", error, 0);
    l0 = n_load;
    run_seq(4'd2, 8, 0, 0, 4, 1);
    chk("held_change_one_load", n_load - l0, 1);
    m = 4'($urandom_range(0, 3));
    exp_req.push_back(m);
    exp_load.push_back(m);
    exp_req.push_back(m + 1);
    exp_load.push_back(m + 1);
    vpg_mode = m;
    vpg_mode_change = 1;
    cyc(1);
    vpg_mode_change = 0;
    cyc(3);
    frame_end = 1;
    cyc(1);
    frame_end = 0;
    pulse_ack(2);
    cyc(2);
    vpg_mode = m + 1;
    vpg_mode_change = 1;
    cyc(1);
    vpg_mode_change = 0;
    wait_sig(1, 40, "pending_load1");
    cyc(1);
    chk("pending_req_reenter", pll_reconfig_req, 1);
    chk("pending_video_off", video_enable, 0);
    chk("pending_busy", busy, 1);
    pulse_ack(2);
    wait_sig(1, 40, "pending_load2");
    cyc(1);
    chk("pending_video_on", video_enable, 1);
    chk("pending_active", active_mode, m + 1);
    m = 4'($urandom_range(0, 4));
    exp_req.push_back(m);
    exp_load.push_back(m);
    pll_locked = 0;
    vpg_mode = m;
    vpg_mode_change = 1;
    cyc(1);
    vpg_mode_change = 0;
    cyc(2);
    frame_end = 1;
    cyc(1);
    frame_end = 0;
    pulse_ack(1);
    cyc(3);
    early = 0;
    pll_locked = 1;
    repeat (15) begin
      cyc(1);
      early |= timing_load;
    end
    pll_locked = 0;
    cyc(1);
    early |= timing_load;
    pll_locked = 1;
    repeat (17) begin
      cyc(1);
      early |= timing_load;
    end
    chk("no_load_before_stable", early, 0);
    wait_sig(1, 10, "load_after_stable");
    cyc(1);
    chk("lock_video_on", video_enable, 1);
    m = 4'($urandom_range(0, 4));
    exp_req.push_back(m);
    exp_req.push_back(m);
    exp_load.push_back(m);
    vpg_mode = m;
    vpg_mode_change = 1;
    cyc(1);
    vpg_mode_change = 0;
    cyc(2);
    frame_end = 1;
    cyc(1);
    frame_end = 0;
    chk("to_req_up", pll_reconfig_req, 1);
    chk("to_err_clear", error, 0);
    n = 0;
    while (pll_reconfig_req && n < 100) begin
      cyc(1);
      n++;
    end
    chk("to_window", n >= 60 && n <= 66, 1);
    chk("to_err_set", error, 1);
    cyc(1);
    chk("to_req_reassert", pll_reconfig_req, 1);
    chk("to_err_sticky", error, 1);
    pulse_ack(2);
    wait_sig(1, 40, "to_load");
    cyc(1);
    chk("to_err_cleared", error, 0);
    chk("to_video_on", video_enable, 1);
    for (int r = 0; r < 6; r++) begin
      m = 4'($urandom_range(0, 4));
      x = 4'($urandom_range(0, 15));
      run_seq(m, $urandom_range(1, 8), 1'($urandom_range(0, 1)), x, $urandom_range(1, 20), $urandom_range(0, 6));
      chk("rand_error", error, 0);
    end
    m = 4'($urandom_range(0, 3));
    exp_req.push_back(m);
    vpg_mode = m;
    vpg_mode_change = 1;
    cyc(1);
    vpg_mode_change = 0;
    cyc(2);
    frame_end = 1;
    cyc(1);
    frame_end = 0;
    cyc(2);
    chk("mid_req_high", pll_reconfig_req, 1);
    #3 reset_n = 0;
    #1;
    chk("async_req_drop", pll_reconfig_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_video", video_enable, 0);
    chk("mid_rst_load", timing_load, 0);
    chk("mid_rst_pll_mode", pll_mode, 4);
    chk("mid_rst_active", active_mode, 4);
    #3 reset_n = 1;
    pulse_ack(1);
    cyc(30);
    chk("idle_after_reset", busy, 0);
    chk("active_after_reset", active_mode, 4);
    chk("load_queue_empty", exp_load.size(), 0);
    chk("req_queue_empty", exp_req.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vpg_mode_apply.md
# vpg_mode_apply

Responder side of the video-pattern-generator mode-change interface. It consumes the `vpg_mode` / `vpg_mode_change` pair produced by the mode selector and runs the reconfiguration sequence: blank video at a frame boundary, hand the new mode to the pixel-PLL reconfiguration controller, wait for stable lock, then load the timing generator and re-enable video. It sits between the mode selector and the PLL reconfig / timing-generator blocks in the HDMI pattern path.

## Interface
- `LOCK_STABLE`, 16: consecutive cycles `pll_locked` must be high before lock is accepted (≥1).
- `TIMEOUT_W`, 20: width of the timeout counter; the timeout fires after 2^TIMEOUT_W−1 cycles in a waiting state.
- `clk` input 1: single system clock; all logic rises on it.
- `reset_n` input 1: asynchronous, active-low reset.
- `vpg_mode_change` input 1: change strobe from the mode selector; level may last several cycles; only its rising edge is used.
- `vpg_mode` input 4: requested mode code (vpg.h: `VGA_640x480p60` … `FHD_1920x1080p60`).
- `frame_end` input 1: one-cycle pulse from the timing generator on the last pixel of a frame.
- `pll_reconfig_ack` input 1: reconfig controller accepted `pll_mode`.
- `pll_locked` input 1: pixel PLL lock, asynchronous to `clk`; double-flopped internally.
- `pll_reconfig_req` output 1: reconfig request, level, held until ack.
- `pll_mode` output 4: mode presented to the reconfig controller; stable while req is high.
- `timing_load` output 1: one-cycle pulse; the timing generator loads `active_mode` parameters.
- `active_mode` output 4: mode currently applied to the timing generator.
- `video_enable` output 1: pixel output gate.
- `busy` output 1: high in any state other than IDLE.
- `error` output 1: sticky timeout flag.

## Operation
- Edge detect: `chg = vpg_mode_change & ~chg_d`, where `chg_d` is registered. A `chg` with an out-of-range code (> `FHD_1920x1080p60`) is ignored entirely.
- `target` register: loaded from `vpg_mode` on every valid `chg`, in any state.
- States:
  - **IDLE**: on valid `chg`, go to DRAIN.
  - **DRAIN**: `video_enable`=0.
    - On `frame_end`, or on timeout, go to REQ.
    - A drain timeout does not set `error`.
  - **REQ**: `pll_mode`←`target` on entry; `pll_reconfig_req`=1.
    - On sampled `pll_reconfig_ack`, deassert req and go to WAIT_LOCK.
    - On timeout: set `error`, drop req for 1 cycle, re-enter REQ.
  - **WAIT_LOCK**: count consecutive synchronized `pll_locked`=1 cycles; the count resets to 0 on any low.
    - When count = `LOCK_STABLE`, go to LOAD.
    - On timeout: set `error`, go to REQ.
  - **LOAD**: `active_mode`←`pll_mode`; `timing_load`=1 for exactly 1 cycle; `error` cleared.
    - If `pending`: clear it and go to REQ, with video staying off.
    - Otherwise go to IDLE with `video_enable`←1.
- `pending`: set by a valid `chg` in REQ, WAIT_LOCK or LOAD. A `chg` in DRAIN only updates `target`.
- The timeout counter clears on every state entry. It saturates and does not wrap.
- Reset values:
  - `pll_reconfig_req`=0, `timing_load`=0, `busy`=0, `error`=0, `video_enable`=0.
  - `pll_mode`=`active_mode`=`FHD_1920x1080p60`.
  - `target`=`FHD_1920x1080p60`; `pending`=0; state IDLE; `chg_d`=1 (no false edge out of reset).
  - Video stays off after reset until the first completed sequence.
- Reset mid-sequence: all state drops to reset values immediately; `pll_reconfig_req` falls asynchronously.

## Timing
- Valid `chg` in IDLE at cycle N → `busy`=1 and `video_enable`=0 at N+1.
- `frame_end` at cycle F in DRAIN → `pll_reconfig_req`=1 and `pll_mode` valid at F+1.
- `pll_reconfig_ack` high at cycle A → `pll_reconfig_req`=0 at A+1.
- Lock latency: 2 sync cycles + `LOCK_STABLE` cycles after `pll_locked` rises and stays high.
- `timing_load` pulses in the cycle after lock is accepted. `video_enable`=1 and `busy`=0 follow one cycle later.
- `frame_end` and `chg` in the same DRAIN cycle: take the frame boundary; `target` takes the new code.

## Test plan
- Reset, then `vpg_mode_change` rises with mode=`VGA_640x480p60`, `frame_end` 5 cycles later, ack after 3 cycles, lock held → `pll_mode`=VGA; `timing_load` exactly 1 pulse; `active_mode`=VGA; `video_enable`=1; `error`=0.
- `vpg_mode_change` held high 8 cycles → exactly one sequence; `timing_load` count = 1.
- Second `chg` (mode+1) during WAIT_LOCK → after the first LOAD, REQ is re-entered with `pll_mode`=mode+1; `video_enable` stays 0 until the second LOAD.
- `pll_locked` toggles low at stable count 15 (`LOCK_STABLE`=16) → no LOAD until 16 uninterrupted high cycles.
- Ack never arrives (`TIMEOUT_W`=6) → `error`=1 after 63 cycles, req drops for 1 cycle then reasserts; later ack and lock → LOAD clears `error`.
- `reset_n` pulsed low while in REQ → `pll_reconfig_req`=0 immediately; all outputs at reset values; no `timing_load`.
